// File: rtl/door_access_arbiter.sv
// door_access_arbiter: two-keypad round-robin access controller sharing one
// code check and one door strike, with failure lockout and alarm.
// Optional feature macro: DOOR_OVERRIDE_EN (adds the override input).
`timescale 1ns/1ps
module door_access_arbiter #(
    parameter logic [3:0]  ACCESS_CODE = 4'd9,
    parameter int unsigned OPEN_CYCLES = 8,
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [3:0] code0,
    input  logic [3:0] code1,
`ifdef DOOR_OVERRIDE_EN
    input  logic       override,
`endif
    output logic [1:0] grant,
    output logic       open_access_door,
    output logic       alarm,
    output logic [1:0] state_out
);

    localparam int unsigned TIMER_W = 8;
    localparam int unsigned FAIL_W  = 3;
    localparam int unsigned CODE_W  = 4;

    localparam logic [TIMER_W-1:0] OPEN_LOAD  = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD  = TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [FAIL_W-1:0]  FAIL_LIMIT = FAIL_W'(MAX_FAILS);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CHECK  = 2'b01,
        OPEN   = 2'b10,
        LOCKED = 2'b11
    } state_t;

    state_t              state, state_n;
    logic [TIMER_W-1:0]  timer, timer_n;
    logic [FAIL_W-1:0]   fail_cnt, fail_n;
    logic [CODE_W-1:0]   code_q, code_n;
    logic                last_grant, last_n;
    logic [1:0]          grant_n;
    logic                pick;

    // State and datapath registers; outputs are registered from next-state values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            timer            <= '0;
            fail_cnt         <= '0;
            code_q           <= '0;
            last_grant       <= 1'b1;
            grant            <= 2'b00;
            open_access_door <= 1'b0;
            alarm            <= 1'b0;
        end else begin
            state            <= state_n;
            timer            <= timer_n;
            fail_cnt         <= fail_n;
            code_q           <= code_n;
            last_grant       <= last_n;
            grant            <= grant_n;
            open_access_door <= (state_n == OPEN);
            alarm            <= (state_n == LOCKED);
        end
    end

    // Next-state, arbitration, code check and window timing
    always_comb begin
        state_n = state;
        timer_n = timer;
        fail_n  = fail_cnt;
        code_n  = code_q;
        last_n  = last_grant;
        grant_n = 2'b00;
        pick    = 1'b0;

        case (state)
            IDLE: begin
`ifdef DOOR_OVERRIDE_EN
                if (override) begin
                    state_n = OPEN;
                    timer_n = OPEN_LOAD;
                    fail_n  = '0;
                end else
`endif
                if (req != 2'b00) begin
                    // on a tie the keypad not served last time wins
                    pick    = (req == 2'b11) ? ~last_grant : req[1];
                    code_n  = pick ? code1 : code0;
                    grant_n = pick ? 2'b10 : 2'b01;
                    last_n  = pick;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (code_q == ACCESS_CODE) begin
                    state_n = OPEN;
                    timer_n = OPEN_LOAD;
                    fail_n  = '0;
                end else if (fail_cnt + FAIL_W'(1) == FAIL_LIMIT) begin
                    state_n = LOCKED;
                    timer_n = LOCK_LOAD;
                    fail_n  = '0;
                end else begin
                    fail_n  = fail_cnt + FAIL_W'(1);
                    state_n = IDLE;
                end
            end
            OPEN: begin
                if (timer == '0) begin
                    state_n = IDLE;
                end else begin
                    timer_n = timer - TIMER_W'(1);
                end
            end
            LOCKED: begin
`ifdef DOOR_OVERRIDE_EN
                if (override) begin
                    state_n = OPEN;
                    timer_n = OPEN_LOAD;
                    fail_n  = '0;
                end else
`endif
                if (timer == '0) begin
                    state_n = IDLE;
                end else begin
                    timer_n = timer - TIMER_W'(1);
                end
            end
        endcase
    end

    // State encoding is exported straight from the state register
    assign state_out = state;

endmodule

// File: tb/tb_door_access_arbiter.sv
// Directed self-checking bench for door_access_arbiter (default parameters).
`timescale 1ns/1ps
module tb_door_access_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [3:0] code0;
    logic [3:0] code1;
`ifdef DOOR_OVERRIDE_EN
    logic       override;
`endif
    logic [1:0] grant;
    logic       open_access_door;
    logic       alarm;
    logic [1:0] state_out;

    int n_checks = 0;
    int n_fails  = 0;

    door_access_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .code0            (code0),
        .code1            (code1),
`ifdef DOOR_OVERRIDE_EN
        .override         (override),
`endif
        .grant            (grant),
        .open_access_door (open_access_door),
        .alarm            (alarm),
        .state_out        (state_out)
    );

    // 100 MHz clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_st"},    8'(state_out),        8'd0);
        check_eq({tag, "_door"},  8'(open_access_door), 8'd0);
        check_eq({tag, "_alarm"}, 8'(alarm),            8'd0);
        check_eq({tag, "_gnt"},   8'(grant),            8'd0);
    endtask

    // Present a request for one edge; leaves req driven, DUT now in CHECK
    task automatic request(input string tag, input logic [1:0] r, input logic [3:0] c0,
                           input logic [3:0] c1, input logic [1:0] exp_gnt);
        req   = r;
        code0 = c0;
        code1 = c1;
        tick();
        check_eq({tag, "_gnt"},  8'(grant),            8'(exp_gnt));
        check_eq({tag, "_chk"},  8'(state_out),        8'd1);
        check_eq({tag, "_door"}, 8'(open_access_door), 8'd0);
    endtask

    task automatic fail_once(input string tag, input logic [1:0] r, input logic [3:0] c0,
                             input logic [3:0] c1, input logic [1:0] exp_gnt);
        request(tag, r, c0, c1, exp_gnt);
        req = 2'b00;
        tick();
        check_idle({tag, "_back"});
    endtask

    // n cycles of door (or alarm) high, then one IDLE cycle with it low
    task automatic expect_window(input string tag, input bit lock_win, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq({tag, "_on"},  8'(lock_win ? alarm : open_access_door), 8'd1);
            check_eq({tag, "_st"},  8'(state_out), lock_win ? 8'd3 : 8'd2);
            check_eq({tag, "_gnt"}, 8'(grant), 8'd0);
        end
        tick();
        check_eq({tag, "_off"},  8'(lock_win ? alarm : open_access_door), 8'd0);
        check_eq({tag, "_idle"}, 8'(state_out), 8'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        code0 = 4'd0;
        code1 = 4'd0;
`ifdef DOOR_OVERRIDE_EN
        override = 1'b0;
`endif
        // reset values
        tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();
        tick();
        check_idle("post_reset");

        // open the door shortly before 2.5 us, then reset asynchronously mid-window
        while ($time < 64'd2450) tick();
        request("pre_rst", 2'b01, 4'd9, 4'd0, 2'b01);
        req = 2'b00;
        tick();
        check_eq("pre_rst_door1", 8'(open_access_door), 8'd1);
        tick();
        tick();
        check_eq("pre_rst_door3", 8'(open_access_door), 8'd1);
        check_eq("pre_rst_st3",   8'(state_out),        8'd2);
        tick();
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        tick();
        check_idle("rst_held");
        rst_n = 1'b1;
        tick();
        check_idle("rst_release");

        // round-robin tie with req held: 01, then 10, then 01
        req   = 2'b11;
        code0 = 4'd9;
        code1 = 4'd9;
        tick();
        check_eq("rr1_gnt", 8'(grant), 8'd1);
        check_eq("rr1_chk", 8'(state_out), 8'd1);
        expect_window("rr1", 1'b0, 8);
        tick();
        check_eq("rr2_gnt", 8'(grant), 8'd2);
        check_eq("rr2_chk", 8'(state_out), 8'd1);
        expect_window("rr2", 1'b0, 8);
        tick();
        check_eq("rr3_gnt", 8'(grant), 8'd1);
        req = 2'b00;
        expect_window("rr3", 1'b0, 8);

        // single valid request from keypad 0
        request("single", 2'b01, 4'd9, 4'd0, 2'b01);
        req = 2'b00;
        expect_window("single", 1'b0, 8);

        // lockout from keypad 1; a request during lockout is not served or queued
        fail_once("lk_f1", 2'b10, 4'd0, 4'd0, 2'b10);
        fail_once("lk_f2", 2'b10, 4'd0, 4'd0, 2'b10);
        request("lk_f3", 2'b10, 4'd0, 4'd0, 2'b10);
        req   = 2'b01;
        code0 = 4'd9;
        expect_window("lock", 1'b1, 16);
        req = 2'b00;
        tick();
        check_idle("lock_ignored");

        // two failures, a success clears the count, two more failures do not lock
        fail_once("fc_f1", 2'b01, 4'd3, 4'd0, 2'b01);
        fail_once("fc_f2", 2'b01, 4'd3, 4'd0, 2'b01);
        request("fc_ok", 2'b01, 4'd9, 4'd0, 2'b01);
        req = 2'b00;
        expect_window("fc_open", 1'b0, 8);
        fail_once("fc_f3", 2'b01, 4'd3, 4'd0, 2'b01);
        fail_once("fc_f4", 2'b01, 4'd3, 4'd0, 2'b01);

        // reset clears the pending fail count: one more failure stays unlocked
        rst_n = 1'b0;
        #1;
        check_idle("rst_pulse");
        #1;
        rst_n = 1'b1;
        tick();
        fail_once("rst_fc", 2'b01, 4'd3, 4'd0, 2'b01);

`ifdef DOOR_OVERRIDE_EN
        // fail count is 1: two more failures lock, override reopens the door
        fail_once("ov_f1", 2'b01, 4'd3, 4'd0, 2'b01);
        request("ov_f2", 2'b01, 4'd3, 4'd0, 2'b01);
        req = 2'b00;
        tick();
        check_eq("ov_locked", 8'(state_out), 8'd3);
        check_eq("ov_alarm",  8'(alarm),     8'd1);
        override = 1'b1;
        tick();
        check_eq("ov_open_st", 8'(state_out),        8'd2);
        check_eq("ov_alarm0",  8'(alarm),            8'd0);
        check_eq("ov_door",    8'(open_access_door), 8'd1);
        override = 1'b0;
        expect_window("ov_rest", 1'b0, 7);
        // override beats a simultaneous request in IDLE
        override = 1'b1;
        req      = 2'b01;
        code0    = 4'd3;
        tick();
        check_eq("ov_prio_st",  8'(state_out), 8'd2);
        check_eq("ov_prio_gnt", 8'(grant),     8'd0);
        override = 1'b0;
        req      = 2'b00;
        expect_window("ov_prio", 1'b0, 7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
